// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback encodings, arbiter FSM states and the writeback data mux.
package wb_port_arbiter_pkg;

    localparam logic [1:0] WB_SEL_IMM = 2'b00;
    localparam logic [1:0] WB_SEL_RAM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;

    typedef enum logic [1:0] {
        ARB_EMPTY  = 2'd0,
        ARB_HELD   = 2'd1,
        ARB_STALL  = 2'd2,
        ARB_HALTED = 2'd3
    } arb_state_t;

    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] imm,
                                              input logic [31:0] ram,
                                              input logic [31:0] pc);
        case (sel)
            WB_SEL_IMM: return imm;
            WB_SEL_RAM: return ram;
            WB_SEL_PC:  return pc;
            default:    return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of writeback, multi-cycle result and register-file port signals.
interface wb_port_arbiter_if;
    logic        wb_regwrite;
    logic [1:0]  wb_memtoreg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_ram_data;
    logic [31:0] wb_imm_data;
    logic [31:0] wb_pc;
    logic        wb_halt;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic        halted;
    logic        halt_done;

    modport slave (
        input  wb_regwrite, wb_memtoreg, wb_rd, wb_ram_data, wb_imm_data, wb_pc, wb_halt,
        input  md_valid, md_rd, md_data,
        output md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, halted, halt_done
    );

    modport master (
        output wb_regwrite, wb_memtoreg, wb_rd, wb_ram_data, wb_imm_data, wb_pc, wb_halt,
        output md_valid, md_rd, md_data,
        input  md_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, halted, halt_done
    );
endinterface

// File: rtl/wb_skid_buffer.sv
// One-entry holding buffer for multi-cycle results; accepts only when empty,
// so a capture and a clear can never coincide.
module wb_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        clear,
    output logic        md_ready,
    output logic        buf_valid,
    output logic [4:0]  buf_rd,
    output logic [31:0] buf_data
);
    assign md_ready = !buf_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 32'h0;
        end else if (md_valid && md_ready) begin
            buf_valid <= 1'b1;
            buf_rd    <= md_rd;
            buf_data  <= md_data;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage and a buffered
// multi-cycle result; the pipeline always wins, a starved result forces a stall.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    arb_state_t  state;
    logic [2:0]  starve_cnt;
    logic [2:0]  starve_inc;
    logic        halted;
    logic        pipe_eff;
    logic        handshake;
    logic        buf_valid;
    logic        buf_clear;
    logic [4:0]  buf_rd;
    logic [31:0] buf_data;

    assign halted    = (state == ARB_HALTED);
    assign pipe_eff  = bus.wb_regwrite && (bus.wb_rd != 5'd0) && !halted;
    assign handshake = bus.md_valid && bus.md_ready;
    // Drain when the port is free; discard when the pipeline overwrites the same register.
    assign buf_clear = buf_valid && (!pipe_eff || (bus.wb_rd == buf_rd));

    wb_skid_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .md_valid  (bus.md_valid),
        .md_rd     (bus.md_rd),
        .md_data   (bus.md_data),
        .clear     (buf_clear),
        .md_ready  (bus.md_ready),
        .buf_valid (buf_valid),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data)
    );

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'h0;
        if (!rst) begin
            if (pipe_eff) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = bus.wb_rd;
                bus.rf_wdata = wb_select(bus.wb_memtoreg, bus.wb_imm_data,
                                         bus.wb_ram_data, bus.wb_pc);
            end else if (buf_valid && (buf_rd != 5'd0)) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = buf_rd;
                bus.rf_wdata = buf_data;
            end
        end
    end

    assign bus.pipe_stall = (state == ARB_STALL);
    assign bus.halted     = halted;
    assign bus.halt_done  = halted && !buf_valid && !bus.md_valid;

    assign starve_inc = (starve_cnt == 3'h7) ? starve_cnt : starve_cnt + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_EMPTY;
            starve_cnt <= 3'd0;
        end else if (bus.wb_halt && !halted) begin
            state <= ARB_HALTED;
        end else begin
            case (state)
                ARB_EMPTY: begin
                    if (handshake) state <= ARB_HELD;
                end
                ARB_HELD: begin
                    if (buf_clear) begin
                        state      <= ARB_EMPTY;
                        starve_cnt <= 3'd0;
                    end else begin
                        starve_cnt <= starve_inc;
                        if (starve_inc >= LIMIT) state <= ARB_STALL;
                    end
                end
                ARB_STALL: begin
                    if (buf_clear) begin
                        state      <= ARB_EMPTY;
                        starve_cnt <= 3'd0;
                    end else begin
                        starve_cnt <= starve_inc;
                    end
                end
                default: state <= ARB_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model checked every cycle.
module tb_wb_port_arbiter;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending md results as a queue, a halt flag and a count of lost cycles.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t pend[$];
    bit   m_halted = 1'b0;
    int   m_losses = 0;
    bit   m_eff;
    bit   m_hs;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] imm,
                                         input logic [31:0] ram, input logic [31:0] pc);
        case (sel)
            2'b00:   return imm;
            2'b01:   return ram;
            2'b10:   return pc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_halted = 1'b0;
            m_losses = 0;
        end else begin
            m_eff = bus.wb_regwrite && (bus.wb_rd != 5'd0) && !m_halted;
            m_hs  = bus.md_valid && (pend.size() == 0);
            if (pend.size() != 0) begin
                if (!m_eff || (bus.wb_rd == pend[0].rd)) begin
                    void'(pend.pop_front());
                    m_losses = 0;
                end else begin
                    m_losses++;
                end
            end
            if (m_hs) pend.push_back('{rd: bus.md_rd, data: bus.md_data});
            if (bus.wb_halt) m_halted = 1'b1;
        end
    end

    bit          e_eff;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_md_ready",   32'(bus.md_ready),   32'h0);
            chk("rst_rf_we",      32'(bus.rf_we),      32'h0);
            chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'h0);
            chk("rst_halt_done",  32'(bus.halt_done),  32'h0);
        end else begin
            e_eff  = bus.wb_regwrite && (bus.wb_rd != 5'd0) && !m_halted;
            e_we   = 1'b0;
            e_addr = 5'd0;
            e_data = 32'h0;
            if (e_eff) begin
                e_we   = 1'b1;
                e_addr = bus.wb_rd;
                e_data = pick(bus.wb_memtoreg, bus.wb_imm_data, bus.wb_ram_data, bus.wb_pc);
            end else if ((pend.size() != 0) && (pend[0].rd != 5'd0)) begin
                e_we   = 1'b1;
                e_addr = pend[0].rd;
                e_data = pend[0].data;
            end
            chk("m_rf_we", 32'(bus.rf_we), 32'(e_we));
            if (e_we) begin
                chk("m_rf_waddr", 32'(bus.rf_waddr), 32'(e_addr));
                chk("m_rf_wdata", bus.rf_wdata, e_data);
            end
            chk("m_md_ready",   32'(bus.md_ready),   32'(pend.size() == 0));
            chk("m_pipe_stall", 32'(bus.pipe_stall),
                32'(!m_halted && (pend.size() != 0) && (m_losses >= LIMIT)));
            chk("m_halted",     32'(bus.halted),     32'(m_halted));
            chk("m_halt_done",  32'(bus.halt_done),
                32'(m_halted && (pend.size() == 0) && !bus.md_valid));
        end
    end

    task automatic drive_wb(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                            input logic [31:0] imm, input logic [31:0] ram, input logic [31:0] pc);
        bus.wb_regwrite = we;
        bus.wb_memtoreg = sel;
        bus.wb_rd       = rd;
        bus.wb_imm_data = imm;
        bus.wb_ram_data = ram;
        bus.wb_pc       = pc;
    endtask

    task automatic drive_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.md_valid = v;
        bus.md_rd    = rd;
        bus.md_data  = d;
    endtask

    task automatic idle();
        drive_wb(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        drive_md(1'b0, 5'd0, 32'h0);
        bus.wb_halt = 1'b0;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("init_md_ready", 32'(bus.md_ready), 32'h0);
        chk("init_rf_we",    32'(bus.rf_we),    32'h0);
        chk("init_halted",   32'(bus.halted),   32'h0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        step_clk();

        // Single md result, no pipeline traffic.
        drive_md(1'b1, 5'd5, 32'hAAAA0001);
        mid();
        chk("s1_c0_md_ready", 32'(bus.md_ready), 32'h1);
        chk("s1_c0_rf_we",    32'(bus.rf_we),    32'h0);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        mid();
        chk("s1_c1_rf_we",    32'(bus.rf_we),    32'h1);
        chk("s1_c1_rf_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("s1_c1_rf_wdata", bus.rf_wdata,      32'hAAAA0001);
        chk("s1_c1_md_ready", 32'(bus.md_ready), 32'h0);
        step_clk();
        mid();
        chk("s1_c2_md_ready", 32'(bus.md_ready), 32'h1);
        chk("s1_c2_rf_we",    32'(bus.rf_we),    32'h0);
        step_clk();

        // Writeback data select for RAM and the unused encoding.
        drive_wb(1'b1, 2'b01, 5'd8, 32'h1, 32'h0000BEEF, 32'h2);
        mid();
        chk("sel_ram_wdata", bus.rf_wdata, 32'h0000BEEF);
        step_clk();
        drive_wb(1'b1, 2'b11, 5'd8, 32'h1, 32'h0000BEEF, 32'h2);
        mid();
        chk("sel_zero_wdata", bus.rf_wdata, 32'h0);
        step_clk();
        idle();

        // Starvation: rd=7 held while the pipeline writes rd=3 for five cycles.
        drive_md(1'b1, 5'd7, 32'h77770007);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive_wb(1'b1, 2'b00, 5'd3, 32'h300 + 32'(i), 32'h0, 32'h0);
            mid();
            chk("s2_pipe_waddr", 32'(bus.rf_waddr),   32'd3);
            chk("s2_pipe_stall", 32'(bus.pipe_stall), 32'(i >= 3));
            step_clk();
        end
        drive_wb(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
        mid();
        chk("s2_drain_we",    32'(bus.rf_we),      32'h1);
        chk("s2_drain_waddr", 32'(bus.rf_waddr),   32'd7);
        chk("s2_drain_wdata", bus.rf_wdata,        32'h77770007);
        chk("s2_drain_stall", 32'(bus.pipe_stall), 32'h1);
        step_clk();
        mid();
        chk("s2_after_stall", 32'(bus.pipe_stall), 32'h0);
        chk("s2_after_ready", 32'(bus.md_ready),   32'h1);
        step_clk();

        // Pipeline write to the buffered register supersedes the md result.
        drive_md(1'b1, 5'd9, 32'h99990009);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        drive_wb(1'b1, 2'b10, 5'd9, 32'h1, 32'h2, 32'h40);
        mid();
        chk("s3_waddr", 32'(bus.rf_waddr), 32'd9);
        chk("s3_wdata", bus.rf_wdata,      32'h40);
        step_clk();
        idle();
        mid();
        chk("s3_no_md_write", 32'(bus.rf_we),    32'h0);
        chk("s3_md_ready",    32'(bus.md_ready), 32'h1);
        step_clk();

        // A pipeline write to x0 does not block the buffer.
        drive_md(1'b1, 5'd17, 32'h11110011);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        drive_wb(1'b1, 2'b00, 5'd0, 32'hDEAD, 32'h0, 32'h0);
        mid();
        chk("s4_we",    32'(bus.rf_we),    32'h1);
        chk("s4_waddr", 32'(bus.rf_waddr), 32'd17);
        chk("s4_wdata", bus.rf_wdata,      32'h11110011);
        step_clk();
        idle();
        mid();
        chk("s4_md_ready", 32'(bus.md_ready), 32'h1);
        step_clk();

        // Reset pulsed while stalled.
        drive_md(1'b1, 5'd12, 32'hCCCC000C);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        drive_wb(1'b1, 2'b00, 5'd4, 32'h44, 32'h0, 32'h0);
        repeat (3) begin
            mid();
            step_clk();
        end
        mid();
        chk("s5_stalled", 32'(bus.pipe_stall), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("s5_rst_rf_we",      32'(bus.rf_we),      32'h0);
        chk("s5_rst_rf_waddr",   32'(bus.rf_waddr),   32'h0);
        chk("s5_rst_rf_wdata",   bus.rf_wdata,        32'h0);
        chk("s5_rst_md_ready",   32'(bus.md_ready),   32'h0);
        chk("s5_rst_pipe_stall", 32'(bus.pipe_stall), 32'h0);
        chk("s5_rst_halt_done",  32'(bus.halt_done),  32'h0);
        chk("s5_rst_halted",     32'(bus.halted),     32'h0);
        idle();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        step_clk();
        mid();
        chk("s5_no_stale_write", 32'(bus.rf_we),    32'h0);
        chk("s5_md_ready",       32'(bus.md_ready), 32'h1);
        step_clk();

        // Halt with a pending md result.
        drive_md(1'b1, 5'd21, 32'h15150015);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        bus.wb_halt = 1'b1;
        drive_wb(1'b1, 2'b00, 5'd2, 32'h2222, 32'h0, 32'h0);
        mid();
        chk("s6_halt_we",     32'(bus.rf_we),    32'h1);
        chk("s6_halt_waddr",  32'(bus.rf_waddr), 32'd2);
        chk("s6_halt_wdata",  bus.rf_wdata,      32'h2222);
        chk("s6_halt_halted", 32'(bus.halted),   32'h0);
        step_clk();
        bus.wb_halt = 1'b0;
        drive_wb(1'b1, 2'b00, 5'd6, 32'h6666, 32'h0, 32'h0);
        mid();
        chk("s6_halted",      32'(bus.halted),     32'h1);
        chk("s6_drain_waddr", 32'(bus.rf_waddr),   32'd21);
        chk("s6_drain_wdata", bus.rf_wdata,        32'h15150015);
        chk("s6_drain_done",  32'(bus.halt_done),  32'h0);
        chk("s6_drain_stall", 32'(bus.pipe_stall), 32'h0);
        step_clk();
        mid();
        chk("s6_ignored_we", 32'(bus.rf_we),     32'h0);
        chk("s6_done",       32'(bus.halt_done), 32'h1);
        step_clk();
        drive_md(1'b1, 5'd26, 32'h1A1A001A);
        mid();
        chk("s6_hs_ready", 32'(bus.md_ready),  32'h1);
        chk("s6_hs_done",  32'(bus.halt_done), 32'h0);
        step_clk();
        drive_md(1'b0, 5'd0, 32'h0);
        mid();
        chk("s6_md2_waddr", 32'(bus.rf_waddr),  32'd26);
        chk("s6_md2_done",  32'(bus.halt_done), 32'h0);
        step_clk();
        mid();
        chk("s6_final_done", 32'(bus.halt_done), 32'h1);
        step_clk();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
